// File: rtl/neo_multichannel_if.sv
// Sample/result bundle for neo_multichannel: sample in, energy and spike out.
interface neo_multichannel_if #(
    parameter int N  = 16,
    parameter int CH = 4
);
    localparam int CW = (CH > 1) ? $clog2(CH) : 1;

    logic                  in_valid;
    logic [CW-1:0]         in_ch;
    logic signed [N-1:0]   in_data;
    logic [2*N-1:0]        thresh;
    logic                  out_valid;
    logic [CW-1:0]         out_ch;
    logic signed [2*N:0]   out_energy;
    logic                  out_spike;

    modport master (
        output in_valid, in_ch, in_data, thresh,
        input  out_valid, out_ch, out_energy, out_spike
    );

    modport slave (
        input  in_valid, in_ch, in_data, thresh,
        output out_valid, out_ch, out_energy, out_spike
    );
endinterface

// File: rtl/neo_multichannel.sv
// Time-multiplexed k-lag NEO with per-channel threshold spike detect and refractory.
// NEO_SMOOTH_EN adds a 2-tap per-channel smoother (one extra stage, one extra warm-up sample).
module neo_multichannel #(
    parameter int N    = 16,
    parameter int CH   = 4,
    parameter int K    = 1,
    parameter int REFR = 3
) (
    input  logic              Clk,
    input  logic              reset,
    neo_multichannel_if.slave bus
);
    localparam int CW = (CH > 1) ? $clog2(CH) : 1;
    localparam int HL = 2 * K;
`ifdef NEO_SMOOTH_EN
    localparam int WU = HL + 1;
`else
    localparam int WU = HL;
`endif
    localparam int WW = $clog2(WU + 1);
    localparam int RW = (REFR > 0) ? $clog2(REFR + 1) : 1;

    logic signed [N-1:0] hist [CH][HL];
    logic [WW-1:0]       warm [CH];
    logic [RW-1:0]       refr [CH];

    logic                accept;
    logic [WW-1:0]       warm_cur;

    logic                s0_v;
    logic [CW-1:0]       s0_ch;
    logic signed [N-1:0] s0_x, s0_a, s0_b;

    logic                  s1_v;
    logic [CW-1:0]         s1_ch;
    logic signed [2*N-1:0] s1_p, s1_q;
    logic signed [2*N:0]   psi_c;

    logic                fin_v;
    logic [CW-1:0]       fin_ch;
    logic signed [2*N:0] fin_e;
    logic                spike;

    assign accept   = bus.in_valid && (32'(bus.in_ch) < 32'(CH));
    assign warm_cur = warm[bus.in_ch];

    // S0: operand capture and history shift; x[n-K] at tap K-1, x[n-2K] at tap 2K-1
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            s0_v  <= 1'b0;
            s0_ch <= '0;
            s0_x  <= '0;
            s0_a  <= '0;
            s0_b  <= '0;
            for (int c = 0; c < CH; c++) begin
                warm[c] <= '0;
                for (int i = 0; i < HL; i++)
                    hist[c][i] <= '0;
            end
        end else begin
            s0_v <= accept && (warm_cur >= WW'(HL));
            if (accept) begin
                s0_ch <= bus.in_ch;
                s0_x  <= bus.in_data;
                s0_a  <= hist[bus.in_ch][K-1];
                s0_b  <= hist[bus.in_ch][HL-1];
                hist[bus.in_ch][0] <= bus.in_data;
                for (int i = 1; i < HL; i++)
                    hist[bus.in_ch][i] <= hist[bus.in_ch][i-1];
                if (warm_cur != WW'(WU))
                    warm[bus.in_ch] <= warm_cur + 1'b1;
            end
        end
    end

    // S1: full-precision signed products
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            s1_v  <= 1'b0;
            s1_ch <= '0;
            s1_p  <= '0;
            s1_q  <= '0;
        end else begin
            s1_v  <= s0_v;
            s1_ch <= s0_ch;
            s1_p  <= (2*N)'(s0_a) * (2*N)'(s0_a);
            s1_q  <= (2*N)'(s0_x) * (2*N)'(s0_b);
        end
    end

    assign psi_c = (2*N+1)'(s1_p) - (2*N+1)'(s1_q);

`ifdef NEO_SMOOTH_EN
    logic                s0_e, s1_e;
    logic                s2_v;
    logic [CW-1:0]       s2_ch;
    logic signed [2*N:0] s2_psi, s2_prev;
    logic signed [2*N:0] prev [CH];
    logic signed [2*N+1:0] sum;

    // emit flag: channel already has one psi behind it for the smoother
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            s0_e <= 1'b0;
            s1_e <= 1'b0;
        end else begin
            s0_e <= warm_cur == WW'(WU);
            s1_e <= s0_e;
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            s2_v    <= 1'b0;
            s2_ch   <= '0;
            s2_psi  <= '0;
            s2_prev <= '0;
            for (int c = 0; c < CH; c++)
                prev[c] <= '0;
        end else begin
            s2_v <= s1_v && s1_e;
            if (s1_v) begin
                s2_ch        <= s1_ch;
                s2_psi       <= psi_c;
                s2_prev      <= prev[s1_ch];
                prev[s1_ch]  <= psi_c;
            end
        end
    end

    assign sum    = (2*N+2)'(s2_psi) + (2*N+2)'(s2_prev);
    assign fin_v  = s2_v;
    assign fin_ch = s2_ch;
    assign fin_e  = sum[2*N+1:1];
`else
    assign fin_v  = s1_v;
    assign fin_ch = s1_ch;
    assign fin_e  = psi_c;
`endif

    assign spike = (fin_e > $signed({1'b0, bus.thresh}))
                && (refr[fin_ch] == '0);

    // Output stage: compare, refractory bookkeeping, registered results
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            bus.out_valid  <= 1'b0;
            bus.out_ch     <= '0;
            bus.out_energy <= '0;
            bus.out_spike  <= 1'b0;
            for (int c = 0; c < CH; c++)
                refr[c] <= '0;
        end else begin
            bus.out_valid <= fin_v;
            if (fin_v) begin
                bus.out_ch     <= fin_ch;
                bus.out_energy <= fin_e;
                bus.out_spike  <= spike;
                if (spike)
                    refr[fin_ch] <= RW'(REFR);
                else if (refr[fin_ch] != '0)
                    refr[fin_ch] <= refr[fin_ch] - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_neo_multichannel.sv
// Directed bench for neo_multichannel (default build): warm-up, latency, extremes,
// refractory spikes, mid-stream reset and out-of-range channel drop.
module tb_neo_multichannel;
    localparam int N = 16;

    logic Clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   last_cyc;
    int   t0;

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    neo_multichannel_if #(.N(N), .CH(4)) bus4 ();
    neo_multichannel_if #(.N(N), .CH(3)) bus3 ();

    neo_multichannel #(.N(N), .CH(4), .K(1), .REFR(3)) u_dut (
        .Clk   (Clk),
        .reset (reset),
        .bus   (bus4)
    );

    // CH=3 instance: in_ch=3 is representable but out of range
    neo_multichannel #(.N(N), .CH(3), .K(1), .REFR(3)) u_dut3 (
        .Clk   (Clk),
        .reset (reset),
        .bus   (bus3)
    );

    longint q_e[$];
    int     q_ch[$];
    int     q_sp[$];
    int     q_cy[$];
    longint r_e[$];
    int     r_ch[$];

    always @(negedge Clk) begin
        if (bus4.out_valid) begin
            q_e.push_back(longint'(bus4.out_energy));
            q_ch.push_back(int'(bus4.out_ch));
            q_sp.push_back(int'(bus4.out_spike));
            q_cy.push_back(cyc);
        end
        if (bus3.out_valid) begin
            r_e.push_back(longint'(bus3.out_energy));
            r_ch.push_back(int'(bus3.out_ch));
        end
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint qe(int i);
        return (i < q_e.size()) ? q_e[i] : -64'sd999;
    endfunction
    function automatic int qs(int i);
        return (i < q_sp.size()) ? q_sp[i] : -1;
    endfunction
    function automatic int qc(int i);
        return (i < q_ch.size()) ? q_ch[i] : -1;
    endfunction

    task automatic put(input int ch, input int d);
        bus4.in_valid = 1'b1;
        bus4.in_ch    = 2'(ch);
        bus4.in_data  = 16'(d);
        bus3.in_valid = 1'b1;
        bus3.in_ch    = 2'(ch);
        bus3.in_data  = 16'(d);
        @(posedge Clk);
        #1;
        last_cyc      = cyc;
        bus4.in_valid = 1'b0;
        bus3.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic clr();
        q_e.delete();
        q_ch.delete();
        q_sp.delete();
        q_cy.delete();
        r_e.delete();
        r_ch.delete();
    endtask

    task automatic set_thresh(input logic [2*N-1:0] th);
        bus4.thresh = th;
        bus3.thresh = th;
    endtask

    int     s_ch [11] = '{0, 1, 3, 0, 1, 3, 0, 1, 3, 0, 1};
    int     s_d  [11] = '{3, -2, 999, 5, 4, -999, 7, 1, 12345, -1, 0};
    longint x_e  [4]  = '{4, 18, 54, 1};
    int     x_ch [4]  = '{0, 1, 0, 1};
    longint ext_e[3]  = '{3276800, 1073741824, 2147450880};

    initial begin
        bus4.in_valid = 1'b0;
        bus4.in_ch    = '0;
        bus4.in_data  = '0;
        bus3.in_valid = 1'b0;
        bus3.in_ch    = '0;
        bus3.in_data  = '0;
        set_thresh('1);

        #12;
        chk("rst_valid", bus4.out_valid, 0);
        chk("rst_spike", bus4.out_spike, 0);
        chk("rst_energy", bus4.out_energy, 0);
        chk("rst_ch", bus4.out_ch, 0);
        @(negedge Clk);
        reset = 1'b0;
        idle(1);

        // warm-up and latency
        put(0, 0);
        put(0, 100);
        idle(3);
        chk("warmup_none", q_e.size(), 0);
        put(0, 0);
        t0 = last_cyc;
        idle(4);
        chk("first_count", q_e.size(), 1);
        chk("first_energy", qe(0), 10000);
        chk("first_ch", qc(0), 0);
        chk("first_spike", qs(0), 0);
        chk("latency", (q_cy.size() > 0) ? q_cy[0] - t0 : -1, 2);
        chk("hold_valid", bus4.out_valid, 0);
        chk("hold_energy", bus4.out_energy, 10000);
        clr();

        // constant input gives zero energy
        repeat (6) put(2, 50);
        idle(4);
        chk("const_count", q_e.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("const_e%0d", i), qe(i), 0);
            chk($sformatf("const_sp%0d", i), qs(i), 0);
        end
        clr();

        // full-scale extremes
        put(0, -32768);
        put(0, -32768);
        put(0, 32767);
        idle(4);
        chk("ext_count", q_e.size(), 3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("ext_e%0d", i), qe(i), ext_e[i]);
        clr();

        // asynchronous reset with a result in flight
        put(0, 5);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", bus4.out_valid, 0);
        chk("mid_rst_energy", bus4.out_energy, 0);
        chk("mid_rst_spike", bus4.out_spike, 0);
        chk("mid_rst_ch", bus4.out_ch, 0);
        @(posedge Clk);
        #3;
        reset = 1'b0;
        idle(3);
        chk("inflight_drop", q_e.size(), 0);
        put(0, 0);
        put(2, 50);
        put(0, 100);
        idle(3);
        chk("rewarm_none", q_e.size(), 0);
        put(0, 0);
        idle(4);
        chk("rewarm_count", q_e.size(), 1);
        chk("rewarm_energy", qe(0), 10000);
        clr();

        // threshold with refractory suppression
        set_thresh(32'd5000);
        for (int i = 0; i < 12; i++)
            put(1, (i % 2 == 1) ? 100 : 0);
        idle(4);
        chk("refr_count", q_e.size(), 10);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("refr_e%0d", i), qe(i), (i % 2 == 0) ? 10000 : -10000);
            chk($sformatf("refr_sp%0d", i), qs(i), (i % 4 == 0) ? 1 : 0);
            chk($sformatf("refr_ch%0d", i), qc(i), 1);
        end
        set_thresh('1);
        clr();

        // interleaved channels with out-of-range samples on the CH=3 instance
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        idle(1);
        clr();
        for (int i = 0; i < 11; i++)
            put(s_ch[i], s_d[i]);
        idle(4);
        chk("ilv_count", r_e.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ilv_e%0d", i), (i < r_e.size()) ? r_e[i] : -64'sd999, x_e[i]);
            chk($sformatf("ilv_ch%0d", i), (i < r_ch.size()) ? r_ch[i] : -1, x_ch[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
